// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider for the EX stage.
//
// Sequence: IDLE -> SETUP -> CALC (WIDTH cycles) -> DONE -> IDLE.
// Result is packed {remainder, quotient}, ready for a direct HI/LO write.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      request a division (sampled only in IDLE)
//   signed_div 1 = DIV (two's complement), 0 = DIVU; captured with start
//   annul      exception flush; aborts any operation in progress
//   dividend   rs operand, captured with start
//   divisor    rt operand, captured with start
//   busy       high in SETUP and CALC (drives div_stall)
//   ready      one-cycle pulse in DONE: result valid this cycle
//   div_zero   (DIV_ZERO_FAST_EN only) high with ready for a zero divisor
//   result     {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
//
// Optional feature macro: DIV_ZERO_FAST_EN
//   Defined: a zero divisor skips CALC (SETUP -> DONE) and the div_zero
//   output is present. Result values are unchanged.

module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 ready,
`ifdef DIV_ZERO_FAST_EN
    output logic                 div_zero,
`endif
    output logic [2*WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        CALC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;        // dividend as latched
    logic [WIDTH-1:0]   b_q, b_d;        // divisor as latched
    logic               sdiv_q, sdiv_d;  // signed mode
    logic [WIDTH-1:0]   rem_q, rem_d;    // partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;    // dividend magnitude shifting into quotient
    logic [WIDTH-1:0]   dmag_q, dmag_d;  // divisor magnitude
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               negq_q, negq_d;  // negate quotient in DONE
    logic               negr_q, negr_d;  // negate remainder in DONE
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               b_zero;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sdiv_d   = sdiv_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dmag_d   = dmag_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        busy     = 1'b0;
        ready    = 1'b0;
        result   = result_q;

        b_zero  = (b_q == '0);
        // Shifted partial remainder needs WIDTH+1 bits before the subtract.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dmag_q};
        quo_fix = negq_q ? -quo_q : quo_q;
        rem_fix = negr_q ? -rem_q : rem_q;

        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    state_d = SETUP;
                    a_d     = dividend;
                    b_d     = divisor;
                    sdiv_d  = signed_div;
                end
            end
            SETUP: begin
                busy    = 1'b1;
                rem_d   = '0;
                quo_d   = (sdiv_q && a_q[WIDTH-1]) ? -a_q : a_q;
                dmag_d  = (sdiv_q && b_q[WIDTH-1]) ? -b_q : b_q;
                negq_d  = sdiv_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                negr_d  = sdiv_q & a_q[WIDTH-1];
                cnt_d   = CNT_W'(WIDTH);
                state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
                if (b_zero) begin
                    state_d = DONE;
                end
`endif
            end
            CALC: begin
                busy = 1'b1;
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready    = 1'b1;
                // Zero divisor: fixed result, no sign correction.
                result   = b_zero ? {a_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
                result_d = result;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result is presented combinationally during DONE so it is valid
        // alongside ready; a flush in DONE keeps the previous result.
        if (annul && (state_q != IDLE)) begin
            state_d  = IDLE;
            busy     = 1'b0;
            ready    = 1'b0;
            result   = result_q;
            result_d = result_q;
        end
    end

`ifdef DIV_ZERO_FAST_EN
    assign div_zero = ready & b_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sdiv_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dmag_q   <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sdiv_q   <= sdiv_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dmag_q   <= dmag_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter (WIDTH=32).
// Reference results come from plain 64-bit integer division.

module tb_div_iter;

    localparam int W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               signed_div;
    logic               annul;
    logic [W-1:0]       dividend;
    logic [W-1:0]       divisor;
    logic               busy;
    logic               ready;
    logic [2*W-1:0]     result;
`ifdef DIV_ZERO_FAST_EN
    logic               div_zero;
`endif

    int                 checks = 0;
    int                 errors = 0;
    logic [2*W-1:0]     last_exp;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .ready      (ready),
`ifdef DIV_ZERO_FAST_EN
        .div_zero   (div_zero),
`endif
        .result     (result)
    );

    // Reference: truncating division on 64-bit integers; zero divisor gives
    // quotient all ones and remainder = dividend.
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic s);
        longint sa, sb, q, r;
        if (b == '0) return {a, {W{1'b1}}};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] obs,
                       input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one division and watch a fixed window of cycles after acceptance.
    // Cycle c is the interval after acceptance edge + (c-1) edges.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit inject,
                          output int lat, output int nbusy, output int nready,
                          output logic [2*W-1:0] res, output logic dz);
        @(negedge clk);
        start = 1'b1; signed_div = s; dividend = a; divisor = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; signed_div = ~s; dividend = $urandom; divisor = $urandom;
        lat = 0; nbusy = 0; nready = 0; res = 'x; dz = 1'b0;
        for (int c = 1; c <= W + 8; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) nbusy++;
            if (ready) begin
                nready++;
                if (lat == 0) begin
                    lat = c;
                    res = result;
`ifdef DIV_ZERO_FAST_EN
                    dz = div_zero;
`endif
                end
            end
            if (inject && c == 5) begin
                start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic s, input bit inject);
        int lat, nbusy, nready, exp_lat;
        logic [2*W-1:0] res;
        logic dz;
        run_op(a, b, s, inject, lat, nbusy, nready, res, dz);
        exp_lat = W + 2;
`ifdef DIV_ZERO_FAST_EN
        if (b == '0) exp_lat = 2;
        chk({tag, ".div_zero"}, 2*W'(dz), 2*W'(b == '0));
`endif
        chk({tag, ".latency"}, 2*W'(lat), 2*W'(exp_lat));
        chk({tag, ".busy_cycles"}, 2*W'(nbusy), 2*W'(exp_lat - 1));
        chk({tag, ".ready_pulses"}, 2*W'(nready), 2*W'(1));
        last_exp = ref_div(a, b, s);
        chk({tag, ".result"}, res, last_exp);
    endtask

    initial begin
        int nready;
        logic [W-1:0] ra, rb;
        logic rs;

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", 2*W'(busy), '0);
        chk("reset.ready", 2*W'(ready), '0);
        chk("reset.result", result, '0);

        // Reset overrides a simultaneous start.
        start = 1'b1; dividend = 32'd9; divisor = 32'd2;
        @(negedge clk);
        chk("reset_vs_start.busy", 2*W'(busy), '0);
        rst = 1'b0; start = 1'b0;

        // Directed operations.
        check_op("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
        chk("divu_100_7.literal", last_exp, {32'd2, 32'd14});
        check_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        chk("div_m7_2.literal", last_exp, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        chk("div_7_m2.literal", last_exp, {32'h0000_0001, 32'hFFFF_FFFD});
        check_op("div_minneg_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("div_minneg_m1.literal", last_exp, {32'h0, 32'h8000_0000});
        check_op("divu_zero", 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        chk("divu_zero.literal", last_exp, {32'h1234_5678, 32'hFFFF_FFFF});
        check_op("div_zero_neg", 32'hFFFF_FF00, 32'd0, 1'b1, 1'b0);
        check_op("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        check_op("div_neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b0);

        // Annul in cycle 10 of DIVU 50/5.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk);
        @(negedge clk);                    // cycle 1
        start = 1'b0;
        repeat (9) @(negedge clk);         // cycle 10
        annul = 1'b1;
        @(negedge clk);                    // cycle 11
        annul = 1'b0;
        chk("annul.busy", 2*W'(busy), '0);
        chk("annul.ready", 2*W'(ready), '0);
        chk("annul.result_kept", result, last_exp);
        nready = 0;
        for (int c = 0; c < W + 8; c++) begin
            @(negedge clk);
            if (ready) nready++;
        end
        chk("annul.no_ready", 2*W'(nready), '0);
        check_op("after_annul", 32'd50, 32'd5, 1'b0, 1'b0);
        chk("after_annul.literal", last_exp, {32'd0, 32'd10});

        // Annul during DONE suppresses ready and keeps the old result.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd77; divisor = 32'd4;
        @(posedge clk);                    // acceptance edge
        @(negedge clk);
        start = 1'b0;
        repeat (W + 1) @(posedge clk);     // now in DONE
        #1;
        chk("annul_done.reached", 2*W'(ready), 2*W'(1));
        annul = 1'b1;
        #1;
        chk("annul_done.ready", 2*W'(ready), '0);
        chk("annul_done.result", result, last_exp);
        @(posedge clk);
        #1;
        annul = 1'b0;
        chk("annul_done.busy", 2*W'(busy), '0);
        chk("annul_done.result_after", result, last_exp);

        // Start while busy is ignored.
        check_op("start_while_busy", 32'd100, 32'd7, 1'b0, 1'b1);

        // Reset in cycle 20 of an operation.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b1; dividend = 32'hFFFF_F000; divisor = 32'd3;
        @(posedge clk);
        @(negedge clk);                    // cycle 1
        start = 1'b0;
        repeat (19) @(negedge clk);        // cycle 20
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.busy", 2*W'(busy), '0);
        chk("rst_mid.ready", 2*W'(ready), '0);
        chk("rst_mid.result", result, '0);
        nready = 0;
        for (int c = 0; c < W + 8; c++) begin
            @(negedge clk);
            if (ready) nready++;
        end
        chk("rst_mid.no_ready", 2*W'(nready), '0);

        // Randomized operations against the reference.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = -W'($urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            check_op($sformatf("rand%0d", i), ra, rb, rs, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the EX stage of the 5-stage MIPS core.
- Successor to the fixed 32-bit divider that drives div_stall. Adds:
  - WIDTH generalisation
  - explicit start/ready handshake
  - abort on exception flush
  - defined divide-by-zero result
- Result is packed {remainder, quotient} so it writes directly into HI/LO.

Parameters:
- WIDTH, 32: operand width in bits. Legal range is 4 and up.
- CNT_W, $clog2(WIDTH)+1: iteration-counter width. Derived; do not override.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a division. Sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's-complement), 0 = DIVU. Captured with start.
- annul  in  1  exception flush (flush_exceptionM). Aborts the operation in progress.
- dividend  in  WIDTH  rs operand. Captured with start.
- divisor  in  WIDTH  rt operand. Captured with start.
- busy  out  1  division in progress. Feeds div_stall.
- ready  out  1  one-cycle pulse: result is valid this cycle.
- result  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, busy=0, ready=0, result=0, counter=0.
  - Overrides start and annul in the same cycle.
  - Applies mid-operation with no ready pulse.
- States and transitions:
  - IDLE: start=1 and annul=0 -> SETUP. Operands and mode are latched. Otherwise stay.
  - SETUP: take magnitudes if signed_div=1. Record sign_q = a_msb^b_msb and sign_r = a_msb. Clear the partial remainder, load the counter with WIDTH. -> CALC.
  - CALC, one quotient bit per cycle:
    - Shift {rem, quo} left by 1. Trial = rem - divisor_mag, computed in WIDTH+1 bits.
    - If trial is non-negative, rem = trial and quo[0] = 1; otherwise quo[0] = 0.
    - Decrement the counter. When the counter reaches 1 -> DONE.
  - DONE:
    - Apply the signs: quotient negated if sign_q, remainder negated if sign_r (signed only). Register into result.
    - ready=1 for exactly this cycle, then -> IDLE.
- busy:
  - busy=1 in SETUP and CALC; busy=0 in IDLE and DONE.
- Latency: start accepted at edge N -> ready=1 during cycle N+WIDTH+2 (SETUP, then WIDTH CALC cycles, then DONE).
- result holds its value until the next DONE. It is not cleared by start or annul.
- annul=1 in any non-IDLE state:
  - Next state is IDLE, busy drops the next cycle, no ready, result unchanged.
  - annul has priority over start.
  - annul in DONE suppresses ready.
- start while not in IDLE is ignored. Operands are not re-latched.
- Signed rules:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Most-negative / -1 gives quotient = most-negative (wraps) and remainder = 0. No trap.
- Divisor=0, both modes: the algorithm runs the full WIDTH cycles. Required result: quotient = all ones, remainder = dividend as latched, with no sign fix applied to either.
- Unsigned mode never negates.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - SETUP detects divisor==0 and goes directly to DONE. ready comes 2 cycles after acceptance instead of WIDTH+2.
  - Adds an output port div_zero (1 bit). It is high together with ready for a zero-divisor result and 0 otherwise; reset value 0.
  - Result values are the same as without the macro.
- Undefined:
  - No div_zero port.
  - A zero divisor takes the full WIDTH+2 latency.

Test Plan:
- WIDTH=32, DIVU 100/7, start at edge 0 -> busy=1 for cycles 1..33; ready=1 only in cycle 34; result={32'd2, 32'd14}.
- DIV -7/2 (0xFFFFFFF9 / 0x2) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Then DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000, no other signal.
- DIVU 0x12345678 / 0:
  - Without the macro: ready at cycle 34, result={0x12345678, 0xFFFFFFFF}.
  - With DIV_ZERO_FAST_EN: ready at cycle 2 with div_zero=1, same result.
- Start DIVU 50/5, assert annul in cycle 10 -> busy=0 from cycle 11, no ready ever, result keeps its previous value. A new start in cycle 12 completes normally with {0, 10}.
- rst=1 in cycle 20 of an operation, plus a start pulse while busy -> all outputs 0 after the rst edge, no ready. The busy-time start is ignored: ready appears exactly once, at cycle 34 of the original run.
